lsu_sram_bridge: RTL and testbench

- Sits directly downstream of the core load/store unit's data port; terminates the req/gnt/rvalid protocol onto a single-port data SRAM behind an external arbiter.
- Supports back-to-back and split-misaligned sequences: the LSU may hold req for a second access while the first response is pending.
- Range-checks every address; out-of-range accesses never reach the SRAM and return an in-order error response.

---
 rtl/lsu_bus_pkg.sv | 26 ++
 rtl/lsu_rsp_pipe.sv | 42 ++++
 rtl/lsu_sram_bridge.sv | 112 +++++++++++
 tb/tb_lsu_sram_bridge.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_bus_pkg.sv
// lsu_bus_pkg
//   Shared types, defaults and helpers for the LSU-to-SRAM bridge.
//   rsp_meta_t    : per-grant response metadata carried down the response pipe
//   MEM_*_DEFAULT : default SRAM window placement
//   addr_in_range : window check done in 32-bit unsigned arithmetic
package lsu_bus_pkg;

  typedef struct packed {
    logic err;
    logic we;
  } rsp_meta_t;

  localparam logic [31:0] MEM_BASE_DEFAULT = 32'h0001_0000;
  localparam int unsigned MEM_SIZE_DEFAULT = 65536;

  // Subtracting first lets addresses below the base wrap to huge offsets,
  // so a single unsigned compare rejects both sides of the window.
  function automatic logic addr_in_range(input logic [31:0] addr,
                                         input logic [31:0] base,
                                         input logic [31:0] size);
    logic [31:0] offset;
    offset = addr - base;
    return offset < size;
  endfunction

endpackage

// File: rtl/lsu_rsp_pipe.sv
// lsu_rsp_pipe
//   Fixed-depth shift register that delays each grant's valid flag and
//   response metadata so they emerge together with the SRAM read data.
//   clk_i, rst_ni : clock, asynchronous active-low reset (clears all stages)
//   valid_i/meta_i: grant strobe and its metadata entering stage 1
//   valid_o/meta_o: contents of the final stage (Depth cycles later)
module lsu_rsp_pipe
  import lsu_bus_pkg::*;
#(
  parameter int unsigned Depth = 1
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         valid_i,
  input  logic [$bits(rsp_meta_t)-1:0] meta_i,
  output logic                         valid_o,
  output logic [$bits(rsp_meta_t)-1:0] meta_o
);

  localparam int unsigned MetaW = $bits(rsp_meta_t);

  logic [Depth-1:0]            valid_q;
  logic [Depth-1:0][MetaW-1:0] meta_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
      meta_q  <= '0;
    end else begin
      valid_q[0] <= valid_i;
      meta_q[0]  <= meta_i;
      for (int i = 1; i < int'(Depth); i++) begin
        valid_q[i] <= valid_q[i-1];
        meta_q[i]  <= meta_q[i-1];
      end
    end
  end

  assign valid_o = valid_q[Depth-1];
  assign meta_o  = meta_q[Depth-1];

endmodule

// File: rtl/lsu_sram_bridge.sv
// lsu_sram_bridge
//   Terminates the LSU req/gnt/rvalid data protocol onto a single-port SRAM
//   sitting behind an external arbiter. Out-of-window accesses are granted
//   locally, never reach the SRAM, and answer in order with an error.
//   clk_i, rst_ni        : clock, asynchronous active-low reset
//   data_*               : LSU side (req/gnt handshake, in-order rvalid/err/rdata)
//   mem_*                : SRAM side (req/ready handshake, fixed read latency)
//   outstanding_o/busy_o : granted-but-unanswered access count and its nonzero flag
module lsu_sram_bridge
  import lsu_bus_pkg::*;
#(
  parameter logic [31:0] MemBase        = MEM_BASE_DEFAULT,
  parameter int unsigned MemSizeBytes   = MEM_SIZE_DEFAULT,
  parameter int unsigned RdLatency      = 1,
  parameter int unsigned MaxOutstanding = 2,
  localparam int unsigned AW            = $clog2(MemSizeBytes) - 2
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          data_req_i,
  output logic          data_gnt_o,
  output logic          data_rvalid_o,
  output logic          data_err_o,
  input  logic [31:0]   data_addr_i,
  input  logic          data_we_i,
  input  logic [3:0]    data_be_i,
  input  logic [31:0]   data_wdata_i,
  output logic [31:0]   data_rdata_o,
  output logic          mem_req_o,
  input  logic          mem_ready_i,
  output logic          mem_we_o,
  output logic [3:0]    mem_be_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [31:0]   mem_wdata_o,
  input  logic [31:0]   mem_rdata_i,
  output logic [2:0]    outstanding_o,
  output logic          busy_o
);

  logic [31:0] offset;
  logic        in_range;
  logic        credit;
  logic        grant;
  logic        retire;
  logic        unused_offset;
  rsp_meta_t   meta_in;
  rsp_meta_t   meta_out;
  logic [2:0]  outstanding_d, outstanding_q;

  assign offset        = data_addr_i - MemBase;
  assign in_range      = addr_in_range(data_addr_i, MemBase, 32'(MemSizeBytes));
  assign unused_offset = ^{offset[1:0], offset[31:AW+2]};

  // A response leaving the pipe this cycle frees its slot immediately, so a
  // full bridge can still accept a new access in the same cycle.
  assign credit = (outstanding_q < 3'(MaxOutstanding)) | retire;

  // Outputs are held low while reset is asserted, including the
  // combinational handshake and pass-through paths.
  assign grant       = rst_ni & data_req_i & credit & (mem_ready_i | ~in_range);
  assign data_gnt_o  = grant;
  assign mem_req_o   = rst_ni & data_req_i & in_range & credit;
  assign mem_we_o    = rst_ni & data_we_i;
  assign mem_be_o    = {4{rst_ni}} & data_be_i;
  assign mem_addr_o  = {AW{rst_ni}} & offset[AW+1:2];
  assign mem_wdata_o = {32{rst_ni}} & data_wdata_i;

  assign meta_in = '{err: ~in_range, we: data_we_i};

  lsu_rsp_pipe #(
    .Depth (RdLatency)
  ) u_rsp_pipe (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .valid_i (grant),
    .meta_i  (meta_in),
    .valid_o (retire),
    .meta_o  (meta_out)
  );

  // Only a legal read returns SRAM data; writes and errors answer with zero.
  assign data_rvalid_o = retire;
  assign data_err_o    = retire & meta_out.err;
  assign data_rdata_o  = (retire & ~meta_out.err & ~meta_out.we) ? mem_rdata_i : 32'h0;

  always_comb begin
    outstanding_d = outstanding_q;
    if (grant & ~retire) begin
      outstanding_d = outstanding_q + 3'd1;
    end else if (~grant & retire) begin
      outstanding_d = outstanding_q - 3'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      outstanding_q <= 3'd0;
    end else begin
      outstanding_q <= outstanding_d;
    end
  end

  assign outstanding_o = outstanding_q;
  assign busy_o        = (outstanding_q != 3'd0);

  no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(retire && !grant && outstanding_q == 3'd0));

  no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    outstanding_q <= 3'(MaxOutstanding));

endmodule

// File: tb/tb_lsu_sram_bridge.sv
// tb_lsu_sram_bridge
//   Scoreboard bench for lsu_sram_bridge. Instance A uses the default
//   configuration; instance B uses MaxOutstanding=1, RdLatency=2 to exercise
//   the credit limit. Expected responses are queued at grant time and popped
//   when rvalid is due.
module tb_lsu_sram_bridge;

  localparam logic [31:0] BASE = 32'h0001_0000;
  localparam logic [31:0] SIZE = 32'd65536;

  typedef struct {
    int          due;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  logic        clk = 1'b0;
  logic        rstN;
  int          cycle = 0;
  int          testsRun = 0;
  int          testsFailed = 0;
  logic        monOn = 1'b0;
  int          gntCountB = 0;

  logic        reqA, gntA, rvalidA, errA, weA, memReqA, memReadyA, memWeA, busyA;
  logic [31:0] addrA, wdataA, rdataA, memWdataA, memRdataA;
  logic [3:0]  beA, memBeA;
  logic [13:0] memAddrA;
  logic [2:0]  outstandingA;

  logic        reqB, gntB, rvalidB, errB, memReqB, memWeB, busyB;
  logic [31:0] addrB, rdataB, memWdataB, memRdataB, rdB1;
  logic [3:0]  memBeB;
  logic [13:0] memAddrB;
  logic [2:0]  outstandingB;

  logic [31:0] simMem [int];
  logic [31:0] refMem [int];
  exp_t        qA[$];
  exp_t        qB[$];

  always #5 clk = ~clk;
  always @(posedge clk) cycle++;

  lsu_sram_bridge dutA (
    .clk_i(clk), .rst_ni(rstN),
    .data_req_i(reqA), .data_gnt_o(gntA), .data_rvalid_o(rvalidA), .data_err_o(errA),
    .data_addr_i(addrA), .data_we_i(weA), .data_be_i(beA), .data_wdata_i(wdataA),
    .data_rdata_o(rdataA),
    .mem_req_o(memReqA), .mem_ready_i(memReadyA), .mem_we_o(memWeA), .mem_be_o(memBeA),
    .mem_addr_o(memAddrA), .mem_wdata_o(memWdataA), .mem_rdata_i(memRdataA),
    .outstanding_o(outstandingA), .busy_o(busyA)
  );

  lsu_sram_bridge #(.MaxOutstanding(1), .RdLatency(2)) dutB (
    .clk_i(clk), .rst_ni(rstN),
    .data_req_i(reqB), .data_gnt_o(gntB), .data_rvalid_o(rvalidB), .data_err_o(errB),
    .data_addr_i(addrB), .data_we_i(1'b0), .data_be_i(4'hF), .data_wdata_i(32'h0),
    .data_rdata_o(rdataB),
    .mem_req_o(memReqB), .mem_ready_i(1'b1), .mem_we_o(memWeB), .mem_be_o(memBeB),
    .mem_addr_o(memAddrB), .mem_wdata_o(memWdataB), .mem_rdata_i(memRdataB),
    .outstanding_o(outstandingB), .busy_o(busyB)
  );

  function automatic logic [31:0] applyBe(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] fillPattern(input int word);
    return {16'hC0DE, 16'(word)};
  endfunction

  function automatic logic [31:0] readSim(input int word);
    return simMem.exists(word) ? simMem[word] : fillPattern(word);
  endfunction

  function automatic logic [31:0] readRef(input int word);
    return refMem.exists(word) ? refMem[word] : fillPattern(word);
  endfunction

  // SRAM models: A answers one cycle after accept, B two cycles after.
  always @(posedge clk) begin
    if (memReqA && memReadyA) begin
      if (memWeA) simMem[int'(memAddrA)] = applyBe(readSim(int'(memAddrA)), memWdataA, memBeA);
      else memRdataA <= readSim(int'(memAddrA));
    end
    rdB1      <= readSim(int'(memAddrB));
    memRdataB <= rdB1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", tag, actual, expected, cycle);
    end
  endtask

  // Reference model and scoreboard for instance A.
  always @(negedge clk) begin : monA
    logic        inR, expCredit, expGnt, expMemReq, expRv;
    logic [31:0] off;
    exp_t        e;
    if (monOn) begin
      off       = addrA - BASE;
      inR       = off < SIZE;
      expRv     = (qA.size() > 0) && (qA[0].due == cycle);
      expCredit = (qA.size() < 2) || expRv;
      expGnt    = reqA & expCredit & (memReadyA | ~inR);
      expMemReq = reqA & inR & expCredit;
      checkOutput("A_outstanding", 32'(outstandingA), 32'(qA.size()));
      checkOutput("A_busy", 32'(busyA), 32'(qA.size() != 0));
      checkOutput("A_rvalid", 32'(rvalidA), 32'(expRv));
      if (expRv) begin
        e = qA.pop_front();
        checkOutput("A_err", 32'(errA), 32'(e.err));
        checkOutput("A_rdata", rdataA, e.rdata);
      end
      checkOutput("A_gnt", 32'(gntA), 32'(expGnt));
      checkOutput("A_mem_req", 32'(memReqA), 32'(expMemReq));
      if (expMemReq) begin
        checkOutput("A_mem_addr", 32'(memAddrA), 32'(off[15:2]));
        checkOutput("A_mem_we", 32'(memWeA), 32'(weA));
        checkOutput("A_mem_be", 32'(memBeA), 32'(beA));
        checkOutput("A_mem_wdata", memWdataA, wdataA);
      end
      if (expGnt) begin
        e.due   = cycle + 1;
        e.err   = ~inR;
        e.rdata = (inR && !weA) ? readRef(int'(off[15:2])) : 32'h0;
        qA.push_back(e);
        if (inR && weA) refMem[int'(off[15:2])] = applyBe(readRef(int'(off[15:2])), wdataA, beA);
      end
    end
  end

  // Reference model and scoreboard for instance B.
  always @(negedge clk) begin : monB
    logic        expCredit, expGnt, expRv;
    logic [31:0] off;
    exp_t        e;
    if (monOn) begin
      off       = addrB - BASE;
      expRv     = (qB.size() > 0) && (qB[0].due == cycle);
      expCredit = (qB.size() < 1) || expRv;
      expGnt    = reqB & expCredit;
      checkOutput("B_outstanding", 32'(outstandingB), 32'(qB.size()));
      checkOutput("B_rvalid", 32'(rvalidB), 32'(expRv));
      if (expRv) begin
        e = qB.pop_front();
        checkOutput("B_err", 32'(errB), 32'(e.err));
        checkOutput("B_rdata", rdataB, e.rdata);
      end
      checkOutput("B_gnt", 32'(gntB), 32'(expGnt));
      if (expGnt) begin
        gntCountB++;
        e.due   = cycle + 2;
        e.err   = 1'b0;
        e.rdata = readRef(int'(off[15:2]));
        qB.push_back(e);
      end
    end
  end

  // One cycle of instance-A stimulus, driven just after the rising edge.
  task automatic applyStimulus(input logic req, input logic [31:0] addr, input logic we,
                               input logic [3:0] be, input logic [31:0] wdata,
                               input logic ready);
    @(posedge clk);
    #1;
    reqA = req; addrA = addr; weA = we; beA = be; wdataA = wdata; memReadyA = ready;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b1);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_gntA"}, 32'(gntA), 32'h0);
    checkOutput({tag, "_memReqA"}, 32'(memReqA), 32'h0);
    checkOutput({tag, "_memAddrA"}, 32'(memAddrA), 32'h0);
    checkOutput({tag, "_rvalidA"}, 32'(rvalidA), 32'h0);
    checkOutput({tag, "_outstandingA"}, 32'(outstandingA), 32'h0);
    checkOutput({tag, "_busyA"}, 32'(busyA), 32'h0);
    checkOutput({tag, "_gntB"}, 32'(gntB), 32'h0);
    checkOutput({tag, "_rvalidB"}, 32'(rvalidB), 32'h0);
  endtask

  initial begin
    logic [31:0] a;
    int          r;
    rstN = 1'b0;
    reqA = 1'b1; addrA = 32'h0001_0010; weA = 1'b0; beA = 4'hF; wdataA = 32'h0;
    memReadyA = 1'b1; memRdataA = 32'h0;
    reqB = 1'b1; addrB = 32'h0001_0400; memRdataB = 32'h0; rdB1 = 32'h0;
    simMem[4] = 32'hDEAD_BEEF;
    refMem[4] = 32'hDEAD_BEEF;

    // Requests held during reset must be ignored.
    repeat (2) @(negedge clk);
    checkResetOutputs("reset");
    @(posedge clk);
    #1;
    reqA = 1'b0; reqB = 1'b0;
    rstN = 1'b1;
    monOn = 1'b1;

    // Single read, back-to-back pair, window boundaries.
    applyStimulus(1'b1, 32'h0001_0010, 1'b0, 4'hF, 32'h0, 1'b1);
    idle(2);
    applyStimulus(1'b1, 32'h0001_0004, 1'b0, 4'hF, 32'h0, 1'b1);
    applyStimulus(1'b1, 32'h0001_0008, 1'b0, 4'hF, 32'h0, 1'b1);
    idle(2);
    applyStimulus(1'b1, 32'h0000_FFFC, 1'b0, 4'hF, 32'h0, 1'b0);
    applyStimulus(1'b1, 32'h0002_0000, 1'b1, 4'hF, 32'h1234_5678, 1'b0);
    applyStimulus(1'b1, 32'h0001_FFFC, 1'b0, 4'hF, 32'h0, 1'b1);
    idle(2);

    // Arbiter stall: three refused cycles, then accepted.
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 32'h0001_0020, 1'b0, 4'hF, 32'h0, 1'b0);
    applyStimulus(1'b1, 32'h0001_0020, 1'b0, 4'hF, 32'h0, 1'b1);
    idle(2);

    // Partial write, zero-enable write, then read back interleaved with an error.
    applyStimulus(1'b1, 32'h0001_0030, 1'b1, 4'b0101, 32'hAABB_CCDD, 1'b1);
    applyStimulus(1'b1, 32'h0001_0030, 1'b1, 4'b0000, 32'hFFFF_FFFF, 1'b1);
    applyStimulus(1'b1, 32'h0001_0030, 1'b0, 4'hF, 32'h0, 1'b1);
    applyStimulus(1'b1, 32'h0003_0000, 1'b0, 4'hF, 32'h0, 1'b1);
    applyStimulus(1'b1, 32'h0001_0010, 1'b0, 4'hF, 32'h0, 1'b1);
    idle(2);

    // Random traffic around and inside the window.
    for (int i = 0; i < 60; i++) begin
      r = int'($urandom_range(0, 7));
      if (r == 0) a = BASE - 32'(4 * $urandom_range(1, 4)) + 32'($urandom_range(0, 3));
      else if (r == 1) a = BASE + SIZE + 32'(4 * $urandom_range(0, 3));
      else a = BASE + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
      applyStimulus(($urandom_range(0, 3) != 0), a, $urandom_range(0, 1) == 1,
                    4'($urandom_range(0, 15)), $urandom, ($urandom_range(0, 2) != 0));
    end
    idle(3);

    // Reset while a read is in flight: its response must never appear.
    applyStimulus(1'b1, 32'h0001_0010, 1'b0, 4'hF, 32'h0, 1'b1);
    @(negedge clk);
    #1;
    rstN = 1'b0;
    monOn = 1'b0;
    reqA = 1'b0;
    qA.delete();
    qB.delete();
    repeat (2) @(negedge clk);
    checkResetOutputs("midreset");
    @(posedge clk);
    #1;
    rstN = 1'b1;
    monOn = 1'b1;
    idle(4);

    // Credit limit on instance B: continuous requests for ten cycles.
    @(posedge clk);
    #1;
    gntCountB = 0;
    reqB = 1'b1;
    for (int i = 0; i < 10; i++) begin
      addrB = BASE + 32'h400 + 32'(4 * i);
      if (i < 9) begin
        @(posedge clk);
        #1;
      end
    end
    @(posedge clk);
    #1;
    reqB = 1'b0;
    checkOutput("B_gnt_count", 32'(gntCountB), 32'd5);

    // Bounded drain of both scoreboards.
    for (int i = 0; i < 10 && (qA.size() != 0 || qB.size() != 0); i++) @(posedge clk);
    @(negedge clk);
    #1;
    checkOutput("A_drain", 32'(qA.size()), 32'h0);
    checkOutput("B_drain", 32'(qB.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
